// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer: parallel-to-serial USB transmitter with bit
// stuffing, NRZI encoding and EOP generation driving D+/D- directly.
// Ports: clk, n_rst (async, active low); tx_data/tx_valid/tx_last and
// tx_ready form the word handshake; d_plus/d_minus are the bus lines;
// busy is high while a packet is in flight; underrun pulses for one
// cycle when a non-final word runs dry and the packet is aborted.
// Optional: define USB_TX_SYNC_GEN_EN to prefix each packet with SYNC.
module usb_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_PERIOD = 8,
    parameter int STUFF_LEN  = 6
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    input  logic                  tx_last,
    output logic                  tx_ready,
    output logic                  d_plus,
    output logic                  d_minus,
    output logic                  busy,
    output logic                  underrun
);

    localparam int TW = $clog2(BIT_PERIOD);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam int OW = $clog2(STUFF_LEN + 1);
`ifdef USB_TX_SYNC_GEN_EN
    localparam logic [DATA_WIDTH-1:0] SYNC =
        {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_STUFF,
        S_SE0,
        S_EOPJ
    } state_t;

    state_t                r_state, w_state;
    logic [TW-1:0]         r_tmr, w_tmr;
    logic [DATA_WIDTH-1:0] r_sr, w_sr;
    logic [DATA_WIDTH-1:0] r_ndata, w_ndata;
    logic [CW-1:0]         r_bits, w_bits;
    logic [OW-1:0]         r_ones, w_ones;
    logic                  r_last, w_last;
    logic                  r_nvalid, w_nvalid;
    logic                  r_nlast, w_nlast;
    logic                  r_line, w_line;
    logic                  r_se0, w_se0;
    logic                  r_half, w_half;
    logic                  r_urun, w_urun;

    logic                  w_bnd;
    logic                  w_acc;
    logic                  w_stuff;
    logic                  w_eow;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_ld_data;
    logic                  w_ld_last;
    logic                  w_emit;
    logic                  w_bit;

    assign w_bnd   = (r_tmr == TW'(BIT_PERIOD - 1));
    assign w_acc   = tx_valid & tx_ready;
    assign w_stuff = (r_ones == OW'(STUFF_LEN));
    // r_bits counts data bits still to send after the one on the line
    assign w_eow   = (r_bits == '0);

    // State register (and the datapath that moves with it)
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= S_IDLE;
            r_tmr    <= '0;
            r_sr     <= '0;
            r_ndata  <= '0;
            r_bits   <= '0;
            r_ones   <= '0;
            r_last   <= 1'b0;
            r_nvalid <= 1'b0;
            r_nlast  <= 1'b0;
            r_line   <= 1'b1;
            r_se0    <= 1'b0;
            r_half   <= 1'b0;
            r_urun   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_tmr    <= w_tmr;
            r_sr     <= w_sr;
            r_ndata  <= w_ndata;
            r_bits   <= w_bits;
            r_ones   <= w_ones;
            r_last   <= w_last;
            r_nvalid <= w_nvalid;
            r_nlast  <= w_nlast;
            r_line   <= w_line;
            r_se0    <= w_se0;
            r_half   <= w_half;
            r_urun   <= w_urun;
        end
    end

    // Next-state logic
    always_comb begin
        w_state   = r_state;
        w_tmr     = w_bnd ? '0 : r_tmr + TW'(1);
        w_sr      = r_sr;
        w_ndata   = r_ndata;
        w_bits    = r_bits;
        w_ones    = r_ones;
        w_last    = r_last;
        w_nvalid  = r_nvalid;
        w_nlast   = r_nlast;
        w_line    = r_line;
        w_se0     = r_se0;
        w_half    = r_half;
        w_urun    = 1'b0;
        w_load    = 1'b0;
        w_ld_data = r_ndata;
        w_ld_last = r_nlast;
        w_emit    = 1'b0;
        w_bit     = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_tmr  = '0;
                w_line = 1'b1;
                w_se0  = 1'b0;
                if (w_acc) begin
                    w_state = S_SHIFT;
                    w_load  = 1'b1;
`ifdef USB_TX_SYNC_GEN_EN
                    // SYNC goes out first; the word waits in the buffer
                    w_ld_data = SYNC;
                    w_ld_last = 1'b0;
                    w_nvalid  = 1'b1;
                    w_ndata   = tx_data;
                    w_nlast   = tx_last;
`else
                    w_ld_data = tx_data;
                    w_ld_last = tx_last;
`endif
                end
            end
            S_SHIFT, S_STUFF: begin
                if (w_acc) begin
                    w_nvalid = 1'b1;
                    w_ndata  = tx_data;
                    w_nlast  = tx_last;
                end
                if (w_bnd) begin
                    if (w_stuff) begin
                        w_state = S_STUFF;
                        w_line  = ~r_line;
                        w_ones  = '0;
                    end else if (!w_eow) begin
                        w_state = S_SHIFT;
                        w_emit  = 1'b1;
                        w_bit   = r_sr[0];
                        w_sr    = r_sr >> 1;
                        w_bits  = r_bits - CW'(1);
                    end else if (r_nvalid || w_acc) begin
                        // a word accepted on this very edge is used directly
                        w_state   = S_SHIFT;
                        w_load    = 1'b1;
                        w_nvalid  = 1'b0;
                        w_ld_data = r_nvalid ? r_ndata : tx_data;
                        w_ld_last = r_nvalid ? r_nlast : tx_last;
                    end else begin
                        w_state = S_SE0;
                        w_se0   = 1'b1;
                        w_half  = 1'b0;
                        w_urun  = ~r_last;
                    end
                end
            end
            S_SE0: begin
                if (w_bnd) begin
                    if (r_half) begin
                        w_state = S_EOPJ;
                        w_se0   = 1'b0;
                        w_line  = 1'b1;
                    end else begin
                        w_half = 1'b1;
                    end
                end
            end
            S_EOPJ: begin
                if (w_bnd) begin
                    w_state = S_IDLE;
                    w_ones  = '0;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_emit = 1'b1;
            w_bit  = w_ld_data[0];
            w_sr   = w_ld_data >> 1;
            w_bits = CW'(DATA_WIDTH - 1);
            w_last = w_ld_last;
        end

        // NRZI: a 1 holds the line, a 0 toggles it
        if (w_emit) begin
            if (w_bit) begin
                w_ones = r_ones + OW'(1);
            end else begin
                w_line = ~r_line;
                w_ones = '0;
            end
        end
    end

    // Output logic
    always_comb begin
        tx_ready = (r_state == S_IDLE) ||
                   ((r_state == S_SHIFT) && w_eow &&
                    !r_last && !r_nvalid);
        d_plus   = r_line & ~r_se0;
        d_minus  = ~r_line & ~r_se0;
        busy     = (r_state != S_IDLE);
        underrun = r_urun;
    end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// tb_usb_tx_serializer: self-checking bench for usb_tx_serializer.
// Table vectors, hand sequences and random packets vs a bit-level model.
module tb_usb_tx_serializer;

    localparam int DW = 8;
    localparam int BP = 8;
    localparam int SL = 6;
`ifdef USB_TX_SYNC_GEN_EN
    localparam int NSYNC = DW;
`else
    localparam int NSYNC = 0;
`endif

    typedef struct packed {
        logic dp;
        logic dm;
        logic bsy;
        logic ur;
        logic rdy;
    } samp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            nb;
        logic [15:0]   lv;
        logic          ur;
    } vec_t;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_last = 1'b0;
    logic          tx_ready;
    logic          d_plus;
    logic          d_minus;
    logic          busy;
    logic          underrun;

    int            n_chk = 0;
    int            n_pass = 0;
    logic [DW-1:0] pk_w[$];
    logic          pk_last;
    samp_t         sq[$];
    bit            m_lv[$];
    vec_t          tbl[9];

    usb_tx_serializer #(
        .DATA_WIDTH(DW),
        .BIT_PERIOD(BP),
        .STUFF_LEN (SL)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_last (tx_last),
        .tx_ready(tx_ready),
        .d_plus  (d_plus),
        .d_minus (d_minus),
        .busy    (busy),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // Reference: data bits LSB first, a 0 inserted after every run of
    // SL ones, then NRZI levels starting from J (1 = J).
    task automatic build_model();
        bit raw[$];
        int ones;
        bit lvl;
        raw = {};
        m_lv = {};
        ones = 0;
        lvl = 1'b1;
        for (int i = 0; i < NSYNC; i++) raw.push_back(i == NSYNC - 1);
        foreach (pk_w[w])
            for (int i = 0; i < DW; i++) raw.push_back(pk_w[w][i]);
        foreach (raw[i]) begin
            if (!raw[i]) lvl = ~lvl;
            m_lv.push_back(lvl);
            if (raw[i]) begin
                ones++;
                if (ones == SL) begin
                    lvl = ~lvl;
                    m_lv.push_back(lvl);
                    ones = 0;
                end
            end else begin
                ones = 0;
            end
        end
    endtask

    function automatic samp_t exp_at(int k, int nb, logic lst);
        samp_t e;
        e = '0;
        if (k < nb * BP) begin
            e.dp = m_lv[k / BP];
            e.dm = ~m_lv[k / BP];
            e.bsy = 1'b1;
        end else if (k < (nb + 2) * BP) begin
            e.bsy = 1'b1;
            e.ur = (k == nb * BP) && !lst;
        end else if (k < (nb + 3) * BP) begin
            e.dp = 1'b1;
            e.bsy = 1'b1;
        end else begin
            e.dp = 1'b1;
        end
        return e;
    endfunction

    // Feeds pk_w back to back; sample 0 is the cycle after acceptance.
    task automatic run_pkt(input int ncyc);
        int idx;
        int guard;
        bit started;
        bit acc;
        idx = 0;
        guard = 0;
        started = 0;
        sq = {};
        while (sq.size() < ncyc && guard < 4000) begin
            @(negedge clk);
            if (started)
                sq.push_back('{d_plus, d_minus, busy, underrun, tx_ready});
            if (idx < pk_w.size()) begin
                tx_valid = 1'b1;
                tx_data = pk_w[idx];
                tx_last = pk_last && (idx == pk_w.size() - 1);
            end else begin
                tx_valid = 1'b0;
                tx_last = 1'b0;
                tx_data = '0;
            end
            acc = tx_valid && tx_ready;
            @(posedge clk);
            if (acc) begin
                idx++;
                started = 1;
            end
            guard++;
        end
        if (sq.size() < ncyc) begin
            n_chk++;
            $display("FAIL timeout: %0d of %0d samples", sq.size(), ncyc);
        end
    endtask

    task automatic check_wave(input string nm);
        int nb;
        int bad;
        samp_t e;
        samp_t g;
        samp_t be;
        samp_t bg;
        nb = m_lv.size();
        bad = -1;
        be = '0;
        bg = '0;
        for (int k = 0; k < sq.size(); k++) begin
            e = exp_at(k, nb, pk_last);
            g = sq[k];
            g.rdy = 1'b0;
            if (bad < 0 && g !== e) begin
                bad = k;
                be = e;
                bg = g;
            end
        end
        n_chk++;
        if (bad < 0) n_pass++;
        else $display("FAIL %s: cycle %0d got %b expected %b",
                      nm, bad, bg, be);
    endtask

    task automatic do_pkt(input string nm);
        build_model();
        run_pkt((m_lv.size() + 3) * BP + 2);
        check_wave(nm);
    endtask

    initial begin
        int nb;
        int cnt;
        int pos;
        logic [15:0] gl;
        logic [15:0] gm;
        logic [15:0] mask;

        tbl[0] = '{8'hB2, 1'b1, 8, 16'h00C4, 1'b0};
        tbl[1] = '{8'h4D, 1'b1, 8, 16'h0091, 1'b0};
        tbl[2] = '{8'h00, 1'b1, 8, 16'h00AA, 1'b0};
        tbl[3] = '{8'h3F, 1'b1, 9, 16'h00BF, 1'b0};
        tbl[4] = '{8'hFF, 1'b1, 9, 16'h003F, 1'b0};
        tbl[5] = '{8'h7E, 1'b1, 9, 16'h0080, 1'b0};
        tbl[6] = '{8'hFC, 1'b1, 9, 16'h00FE, 1'b0};
        tbl[7] = '{8'h4D, 1'b0, 8, 16'h0091, 1'b1};
        tbl[8] = '{8'h00, 1'b0, 8, 16'h00AA, 1'b1};

        #12;
        chk("rst d_plus", d_plus, 1);
        chk("rst d_minus", d_minus, 0);
        chk("rst tx_ready", tx_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst underrun", underrun, 0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

`ifndef USB_TX_SYNC_GEN_EN
        foreach (tbl[i]) begin
            nb = tbl[i].nb;
            pk_w = {tbl[i].data};
            pk_last = tbl[i].last;
            run_pkt((nb + 3) * BP + 2);
            gl = '0;
            gm = '0;
            mask = '0;
            for (int b = 0; b < nb; b++) begin
                gl[b] = sq[b * BP + BP / 2].dp;
                gm[b] = sq[b * BP + BP / 2].dm;
                mask[b] = 1'b1;
            end
            chk($sformatf("v%0d d_plus bits", i), gl, tbl[i].lv);
            chk($sformatf("v%0d d_minus bits", i), gm,
                ~tbl[i].lv & mask);
            cnt = 0;
            pos = 0;
            foreach (sq[k])
                if (sq[k].ur) begin
                    cnt++;
                    pos = k;
                end
            chk($sformatf("v%0d underrun", i), {cnt[15:0], pos[15:0]},
                tbl[i].ur ? {16'd1, 16'(nb * BP)} : 32'd0);
            cnt = 0;
            foreach (sq[k]) if (!sq[k].dp && !sq[k].dm) cnt++;
            chk($sformatf("v%0d se0 len", i), cnt, 2 * BP);
            chk($sformatf("v%0d eop j", i),
                {sq[(nb + 2) * BP].dp, sq[(nb + 2) * BP].dm,
                 sq[(nb + 2) * BP].bsy, sq[(nb + 3) * BP].dp,
                 sq[(nb + 3) * BP].dm, sq[(nb + 3) * BP].bsy},
                6'b101_100);
            build_model();
            check_wave($sformatf("v%0d model", i));
        end
`else
        pk_w = {8'h4D};
        pk_last = 1'b1;
        do_pkt("sync 4D");
        gl = '0;
        mask = '0;
        for (int b = 0; b < DW; b++) begin
            gl[b] = sq[b * BP + BP / 2].dp;
            mask[b] = (b < DW - 1) ? b[0] : 1'b0;
        end
        chk("sync levels", gl, mask);
`endif

        pk_w = {8'hB2, 8'h4D};
        pk_last = 1'b1;
        do_pkt("b2 4d");
        cnt = 0;
        pos = -1;
        foreach (sq[k])
            if (sq[k].rdy && sq[k].bsy) begin
                cnt++;
                pos = k;
            end
        chk("b2 4d ready pulses", cnt, 1);
        chk("b2 4d ready pos", pos, (NSYNC + DW - 1) * BP);

        pk_w = {8'hFF, 8'h01};
        pk_last = 1'b1;
        do_pkt("ff 01");
        pos = -1;
        foreach (sq[k])
            if (pos < 0 && !sq[k].dp && !sq[k].dm) pos = k;
        chk("ff 01 bit times", pos / BP, 17 + NSYNC);

        pk_w = {8'hFF, 8'hFF, 8'hFF};
        pk_last = 1'b0;
        do_pkt("ff ff ff abort");

        pk_w = {8'h00};
        pk_last = 1'b1;
        run_pkt(20);
        chk("pre-rst busy", sq[19].bsy, 1);
        #2 n_rst = 1'b0;
        #1;
        chk("mid rst busy", busy, 0);
        chk("mid rst lines", {d_plus, d_minus}, 2'b10);
        chk("mid rst ready", tx_ready, 1);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post rst idle", {busy, d_plus, d_minus}, 3'b010);

        for (int p = 0; p < 25; p++) begin
            int nw;
            nw = $urandom_range(1, 4);
            pk_w = {};
            for (int j = 0; j < nw; j++)
                pk_w.push_back(($urandom_range(0, 2) == 0) ?
                               8'hFF : DW'($urandom));
            pk_last = ($urandom_range(0, 3) != 0);
            do_pkt($sformatf("rnd%0d", p));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
